inv_subbytes_iter: RTL and testbench

INV_SUBBYTES_ITER -- requirements
Module: inv_subbytes_iter

---
 rtl/aes_pkg.sv | 33 +++
 rtl/invsubword.sv | 16 +
 rtl/inv_subbytes_iter.sv | 96 +++++++++
 tb/tb_inv_subbytes_iter.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES definitions: FSM state encoding, word count and the inverse S-box
// contents used to fill the byte ROMs.
package aes_pkg;

    localparam int unsigned AES_WORDS = 4;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_e;

    // FIPS-197 inverse S-box, indexed by the substituted byte.
    localparam logic [7:0] INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

endpackage

// File: rtl/invsubword.sv
// One 32-bit word of inverse byte substitution: four independent 256x8 byte ROMs.
module invsubword
    import aes_pkg::*;
(
    input  logic [31:0] w,
    output logic [31:0] y
);

    always_comb begin
        y = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            y[8*i +: 8] = INV_SBOX[w[8*i +: 8]];
        end
    end

endmodule

// File: rtl/inv_subbytes_iter.sv
// Iterative AES InvSubBytes: one 32-bit word per cycle through a shared
// invsubword unit, with a valid/ready handshake on both sides.
module inv_subbytes_iter
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] a,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] y
);

    state_e        state_q, state_d;
    logic [1:0]    cnt_q, cnt_d;
    logic [127:0]  data_q, data_d;
    logic          in_ready_q, in_ready_d;
    logic          out_valid_q, out_valid_d;

    logic [6:0]    word_lsb;
    logic [31:0]   sub_in;
    logic [31:0]   sub_out;

    invsubword u_invsubword (
        .w (sub_in),
        .y (sub_out)
    );

    // Word 0 is the most significant; for a 2-bit cnt, (AES_WORDS-1-cnt) == ~cnt.
    assign word_lsb = {~cnt_q, 5'b00000};
    assign sub_in   = data_q[word_lsb +: 32];

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        data_d      = data_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;

        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    data_d     = a;
                    cnt_d      = '0;
                    state_d    = BUSY;
                    in_ready_d = 1'b0;
                end
            end
            BUSY: begin
                data_d[word_lsb +: 32] = sub_out;
                if (cnt_q == 2'(AES_WORDS - 1)) begin
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                end
            end
            default: begin
                state_d     = IDLE;
                cnt_d       = '0;
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            data_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            data_q      <= data_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign y         = data_q;

endmodule

// File: tb/tb_inv_subbytes_iter.sv
// Self-checking bench for inv_subbytes_iter; the reference inverse S-box is
// derived from GF(2^8) arithmetic and the forward S-box affine map.
module tb_inv_subbytes_iter;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] a;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] y;

    int unsigned total = 0;
    int unsigned bad   = 0;

    logic [7:0] fwd_tab [256];
    logic [7:0] inv_tab [256];

    inv_subbytes_iter dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] z);
        logic [7:0] p = 8'h00;
        logic [7:0] xx = x;
        logic [7:0] zz = z;
        for (int i = 0; i < 8; i++) begin
            if (zz[0]) p = p ^ xx;
            xx = xx[7] ? ((xx << 1) ^ 8'h1b) : (xx << 1);
            zz = zz >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
        return (x << n) | (x >> (8 - n));
    endfunction

    function automatic logic [7:0] fwd_sbox(input logic [7:0] b);
        logic [7:0] g = 8'h00;
        if (b != 8'h00) begin
            for (int c = 1; c < 256; c++) begin
                if (gmul(b, 8'(c)) == 8'h01) g = 8'(c);
            end
        end
        return g ^ rotl(g, 1) ^ rotl(g, 2) ^ rotl(g, 3) ^ rotl(g, 4) ^ 8'h63;
    endfunction

    function automatic logic [127:0] model(input logic [127:0] m);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[8*i +: 8] = inv_tab[m[8*i +: 8]];
        return r;
    endfunction

    function automatic logic [127:0] fwd_matrix(input logic [127:0] m);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[8*i +: 8] = fwd_tab[m[8*i +: 8]];
        return r;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a sample point with the DUT idle; leaves it idle at a sample point.
    task automatic run_one(input logic [127:0] din, input logic [127:0] exp, input string tag);
        a         = din;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a        = rand128();
        chk({tag, "_busy_in_ready"}, 128'(in_ready), 128'(0));
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk); #1;
            chk($sformatf("%s_ov_edge%0d", tag, k), 128'(out_valid), 128'(k == 4));
        end
        chk({tag, "_y"}, y, exp);
        @(posedge clk); #1;
        chk({tag, "_idle_ov"}, 128'(out_valid), 128'(0));
        chk({tag, "_idle_ir"}, 128'(in_ready), 128'(1));
    endtask

    initial begin
        logic [127:0] m1, m2, m, held, plain;
        logic [127:0] results[$];
        int           acc_cyc[$];
        int           n_acc;
        logic         acc;

        for (int x = 0; x < 256; x++) fwd_tab[x] = fwd_sbox(8'(x));
        for (int x = 0; x < 256; x++) inv_tab[fwd_tab[x]] = 8'(x);

        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        #2;
        chk("reset_in_ready", 128'(in_ready), 128'(1));
        chk("reset_out_valid", 128'(out_valid), 128'(0));
        chk("reset_y", y, '0);
        #10 reset = 1'b0;
        @(posedge clk); #1;
        chk("idle_hold_ir", 128'(in_ready), 128'(1));
        chk("idle_hold_ov", 128'(out_valid), 128'(0));

        // Known vectors
        run_one(128'h637c777bf26b6fc53001672bfed7ab76, 128'h000102030405060708090a0b0c0d0e0f, "basic");
        run_one({16{8'h63}}, '0, "rom63");
        run_one({16{8'h16}}, {16{8'hff}}, "rom16");
        run_one({16{8'hed}}, {16{8'h53}}, "romed");

        for (int t = 0; t < 6; t++) begin
            m = rand128();
            run_one(m, model(m), $sformatf("rand%0d", t));
        end

        // Backpressure: result held while out_ready is low
        m         = rand128();
        a         = m;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(posedge clk); #1;
        a = rand128();
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk); #1;
            a = rand128();
        end
        chk("bp_ov", 128'(out_valid), 128'(1));
        chk("bp_y", y, model(m));
        held = y;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            a = rand128();
            chk("bp_hold_ov", 128'(out_valid), 128'(1));
            chk("bp_hold_y", y, held);
            chk("bp_hold_ir", 128'(in_ready), 128'(0));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_ov", 128'(out_valid), 128'(0));
        chk("bp_release_ir", 128'(in_ready), 128'(1));

        // Back-to-back with in_valid held high
        m1 = rand128();
        m2 = rand128();
        a = m1;
        in_valid = 1'b1;
        n_acc = 0;
        for (int cyc = 0; cyc < 40 && results.size() < 2; cyc++) begin
            acc = in_ready && in_valid;
            if (out_valid) results.push_back(y);
            @(posedge clk); #1;
            if (acc) begin
                n_acc++;
                acc_cyc.push_back(cyc);
                if (n_acc == 1) a = m2;
                else in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        chk("b2b_accepts", 128'(n_acc), 128'(2));
        chk("b2b_results", 128'(results.size()), 128'(2));
        if (results.size() == 2 && acc_cyc.size() == 2) begin
            chk("b2b_first", results[0], model(m1));
            chk("b2b_second", results[1], model(m2));
            chk("b2b_spacing", 128'(acc_cyc[1] - acc_cyc[0]), 128'(6));
        end

        // Asynchronous reset while BUSY with cnt == 2
        m        = rand128();
        a        = m;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        #2 reset = 1'b1;
        #1;
        chk("mid_reset_ir", 128'(in_ready), 128'(1));
        chk("mid_reset_ov", 128'(out_valid), 128'(0));
        chk("mid_reset_y", y, '0);
        #1 reset = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            chk("post_reset_no_ov", 128'(out_valid), 128'(0));
        end
        m = rand128();
        run_one(m, model(m), "after_reset");

        // Round trip across all 256 byte values
        for (int g = 0; g < 16; g++) begin
            for (int j = 0; j < 16; j++) plain[8*j +: 8] = 8'(16*g + j);
            run_one(fwd_matrix(plain), plain, $sformatf("roundtrip%0d", g));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
